// File: rtl/wdt_pkg.sv
// Shared types and helpers for the windowed watchdog.
package wdt_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    BARK    = 2'd2,
    EXPIRED = 2'd3
  } wdt_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_TIMEOUT = 2'd1,
    CAUSE_EARLY   = 2'd2
  } wdt_cause_t;

  function automatic int prescale_of(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/wdt_prescaler.sv
// Divides clk down to the watchdog tick; tick marks the cycle in which the divider wraps.
module wdt_prescaler #(
  parameter int PRESCALE = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre;

  always_ff @(posedge clk) begin
    if (rst || clr || !run) begin
      pre <= '0;
    end else if (pre == LAST) begin
      pre <= '0;
    end else begin
      pre <= pre + PW'(1);
    end
  end

  assign tick = run && (pre == LAST);

endmodule

// File: rtl/wdt_window.sv
// Windowed watchdog: tick counter checked against a latched window, warning level and
// timeout, escalating from a bark interrupt to a latched bite.
module wdt_window
  import wdt_pkg::*;
#(
  parameter int                  CLK_FREQ_HZ = 3_000_000,
  parameter int                  TICK_HZ     = 1_000,
  parameter int                  CNT_WIDTH   = 16,
  parameter int                  ID_WIDTH    = 5,
  parameter logic [ID_WIDTH-1:0] INT_ID      = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [CNT_WIDTH-1:0] cfg_timeout,
  input  logic [CNT_WIDTH-1:0] cfg_window,
  input  logic [CNT_WIDTH-1:0] cfg_warn,
  input  logic                 kick,
  input  logic                 irq_ack,
  output logic                 tick,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 warn_irq,
  output logic                 bark_irq,
  output logic [ID_WIDTH-1:0]  irq_id,
  output logic [1:0]           cause,
  output logic                 bite,
  output logic [1:0]           state
);

  localparam int PRESCALE = prescale_of(CLK_FREQ_HZ, TICK_HZ);

  wdt_state_t           cur_state, nxt_state;
  wdt_cause_t           cur_cause, nxt_cause;
  logic [CNT_WIDTH-1:0] count_q, nxt_count, count_inc;
  logic [CNT_WIDTH-1:0] lat_timeout, lat_window, lat_warn;
  logic [CNT_WIDTH-1:0] nxt_timeout, nxt_window, nxt_warn_lvl;
  logic                 warn_q, nxt_warn;
  logic                 pre_run, pre_clr, tick_w;
  logic                 expiring, early;

  wdt_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .run  (pre_run),
    .clr  (pre_clr),
    .tick (tick_w)
  );

  assign pre_run   = (cur_state == RUN) || (cur_state == BARK);
  assign count_inc = count_q + CNT_WIDTH'(1);
  assign expiring  = tick_w && (count_inc == lat_timeout);
  assign early     = (lat_window != '0) && (count_q < lat_window);

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state   <= IDLE;
      cur_cause   <= CAUSE_NONE;
      count_q     <= '0;
      warn_q      <= 1'b0;
      lat_timeout <= '0;
      lat_window  <= '0;
      lat_warn    <= '0;
    end else begin
      cur_state   <= nxt_state;
      cur_cause   <= nxt_cause;
      count_q     <= nxt_count;
      warn_q      <= nxt_warn;
      lat_timeout <= nxt_timeout;
      lat_window  <= nxt_window;
      lat_warn    <= nxt_warn_lvl;
    end
  end

  // RUN decisions follow strict priority: disarm, early kick, legal kick, tick.
  always_comb begin
    nxt_state    = cur_state;
    nxt_cause    = cur_cause;
    nxt_count    = count_q;
    nxt_warn     = warn_q;
    nxt_timeout  = lat_timeout;
    nxt_window   = lat_window;
    nxt_warn_lvl = lat_warn;
    pre_clr      = 1'b0;
    case (cur_state)
      IDLE: begin
        nxt_count = '0;
        if (enable) begin
          nxt_state    = RUN;
          nxt_timeout  = (cfg_timeout == '0) ? CNT_WIDTH'(1) : cfg_timeout;
          nxt_window   = cfg_window;
          nxt_warn_lvl = cfg_warn;
        end
      end
      RUN: begin
        if (!enable) begin
          nxt_state = IDLE;
          nxt_count = '0;
          nxt_warn  = 1'b0;
          pre_clr   = 1'b1;
        end else if (kick && early) begin
          nxt_state = BARK;
          nxt_cause = CAUSE_EARLY;
          nxt_count = '0;
        end else if (kick) begin
          nxt_count = '0;
          nxt_warn  = 1'b0;
          pre_clr   = 1'b1;
        end else if (expiring) begin
          nxt_state = BARK;
          nxt_cause = CAUSE_TIMEOUT;
          nxt_count = '0;
        end else if (tick_w) begin
          nxt_count = count_inc;
          if ((lat_warn != '0) && (count_inc == lat_warn)) begin
            nxt_warn = 1'b1;
          end
        end
      end
      BARK: begin
        if (irq_ack) begin
          nxt_state = RUN;
          nxt_cause = CAUSE_NONE;
          nxt_count = '0;
          nxt_warn  = 1'b0;
          pre_clr   = 1'b1;
        end else if (expiring) begin
          nxt_state = EXPIRED;
          nxt_count = '0;
        end else if (tick_w) begin
          nxt_count = count_inc;
        end
      end
      default: begin
      end
    endcase
  end

  assign tick     = tick_w;
  assign count    = count_q;
  assign warn_irq = warn_q;
  assign bark_irq = (cur_state == BARK) || (cur_state == EXPIRED);
  assign irq_id   = bark_irq ? INT_ID : '0;
  assign cause    = cur_cause;
  assign bite     = (cur_state == EXPIRED);
  assign state    = cur_state;

endmodule

// File: tb/tb_wdt_window.sv
// Self-checking bench for wdt_window: directed scenarios plus randomized traffic,
// all compared cycle by cycle against a behavioural model of the watchdog rules.
module tb_wdt_window;

  localparam int              PRESCALE  = 10;
  localparam int              CNT_WIDTH = 16;
  localparam int              ID_WIDTH  = 5;
  localparam logic [4:0]      INT_ID    = 5'd21;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 enable = 1'b0;
  logic                 kick = 1'b0;
  logic                 irq_ack = 1'b0;
  logic [CNT_WIDTH-1:0] cfg_timeout = '0;
  logic [CNT_WIDTH-1:0] cfg_window = '0;
  logic [CNT_WIDTH-1:0] cfg_warn = '0;
  logic                 tick;
  logic [CNT_WIDTH-1:0] count;
  logic                 warn_irq;
  logic                 bark_irq;
  logic [ID_WIDTH-1:0]  irq_id;
  logic [1:0]           cause;
  logic                 bite;
  logic [1:0]           state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model of the watchdog: state 0 idle, 1 run, 2 bark, 3 expired.
  int m_state = 0, m_count = 0, m_pre = 0, m_warn = 0, m_cause = 0;
  int m_to = 0, m_win = 0, m_wrn = 0;

  wdt_window #(
    .CLK_FREQ_HZ (10),
    .TICK_HZ     (1),
    .CNT_WIDTH   (CNT_WIDTH),
    .ID_WIDTH    (ID_WIDTH),
    .INT_ID      (INT_ID)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .cfg_timeout (cfg_timeout),
    .cfg_window  (cfg_window),
    .cfg_warn    (cfg_warn),
    .kick        (kick),
    .irq_ack     (irq_ack),
    .tick        (tick),
    .count       (count),
    .warn_irq    (warn_irq),
    .bark_irq    (bark_irq),
    .irq_id      (irq_id),
    .cause       (cause),
    .bite        (bite),
    .state       (state)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("[TB] FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "[TB] global timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=%0d expected=%0d (cycle %0d, t=%0t)", tag, got, exp, cyc, $time);
    end
  endtask

  function automatic bit expTick();
    return (m_state == 1 || m_state == 2) && (m_pre == PRESCALE - 1);
  endfunction

  task automatic modelStep(input logic r, input logic en, input logic k, input logic a);
    bit t;
    int pre_next;
    t        = expTick();
    pre_next = (m_pre + 1) % PRESCALE;
    if (r) begin
      m_state = 0; m_count = 0; m_pre = 0; m_warn = 0; m_cause = 0;
    end else begin
      case (m_state)
        0: begin
          if (en) begin
            m_state = 1;
            m_to    = (cfg_timeout == 0) ? 1 : int'(cfg_timeout);
            m_win   = int'(cfg_window);
            m_wrn   = int'(cfg_warn);
            m_count = 0;
            m_pre   = 0;
          end
        end
        1: begin
          if (!en) begin
            m_state = 0; m_count = 0; m_warn = 0; m_pre = 0;
          end else if (k && m_win != 0 && m_count < m_win) begin
            m_state = 2; m_cause = 2; m_count = 0; m_pre = pre_next;
          end else if (k) begin
            m_count = 0; m_pre = 0; m_warn = 0;
          end else begin
            m_pre = pre_next;
            if (t) begin
              if (m_count + 1 == m_to) begin
                m_state = 2; m_cause = 1; m_count = 0;
              end else begin
                m_count++;
                if (m_wrn != 0 && m_count == m_wrn) m_warn = 1;
              end
            end
          end
        end
        2: begin
          if (a) begin
            m_state = 1; m_count = 0; m_pre = 0; m_cause = 0; m_warn = 0;
          end else begin
            m_pre = pre_next;
            if (t) begin
              if (m_count + 1 == m_to) begin
                m_state = 3; m_count = 0;
              end else begin
                m_count++;
              end
            end
          end
        end
        default: m_pre = 0;
      endcase
    end
  endtask

  task automatic compareAll();
    checkOutput("state", state, m_state);
    checkOutput("count", count, m_count);
    checkOutput("tick", tick, expTick());
    checkOutput("warn_irq", warn_irq, m_warn);
    checkOutput("bark_irq", bark_irq, m_state >= 2);
    checkOutput("irq_id", irq_id, (m_state >= 2) ? INT_ID : 0);
    checkOutput("cause", cause, m_cause);
    checkOutput("bite", bite, m_state == 3);
  endtask

  task automatic applyStimulus(input logic r, input logic en, input logic k, input logic a);
    rst = r; enable = en; kick = k; irq_ack = a;
    modelStep(r, en, k, a);
    @(posedge clk);
    #1;
    cyc++;
    compareAll();
  endtask

  task automatic arm(input int to, input int win, input int wrn);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    cfg_timeout = CNT_WIDTH'(to);
    cfg_window  = CNT_WIDTH'(win);
    cfg_warn    = CNT_WIDTH'(wrn);
    cyc = 0;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic runToCount(input int target, input bit at_tick, input string tag);
    bit reached = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (m_count == target && (!at_tick || expTick())) begin
        reached = 1'b1;
        break;
      end
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    end
    checkOutput(tag, reached, 1);
  endtask

  task automatic runUntilState(input int st, input string tag);
    bit reached = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (m_state == st) begin
        reached = 1'b1;
        break;
      end
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    end
    checkOutput(tag, reached, 1);
  endtask

  initial begin
    int first_tick, first_warn, first_bark;
    bit saw_bark, bite_dropped;

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("reset_state", state, 0);
    checkOutput("reset_bite", bite, 0);

    // Plain timeout: first tick, warning and bark timing.
    arm(5, 0, 3);
    first_tick = -1; first_warn = -1; first_bark = -1;
    while (cyc < 60) begin
      if (tick && first_tick < 0) first_tick = cyc;
      if (warn_irq && first_warn < 0) first_warn = cyc;
      if (bark_irq && first_bark < 0) first_bark = cyc;
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    end
    checkOutput("first_tick_cycle", first_tick, 10);
    checkOutput("first_warn_cycle", first_warn, 31);
    checkOutput("first_bark_cycle", first_bark, 51);
    checkOutput("timeout_cause", cause, 1);
    checkOutput("timeout_irq_id", irq_id, INT_ID);

    // Early kick inside the closed window.
    arm(8, 3, 0);
    runToCount(1, 1'b0, "reach_count1");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("early_state", state, 2);
    checkOutput("early_cause", cause, 2);
    checkOutput("early_count", count, 0);

    // Legal kicks keep the dog quiet.
    arm(8, 3, 2);
    runToCount(4, 1'b0, "reach_count4");
    checkOutput("warn_before_kick", warn_irq, 1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("legal_warn", warn_irq, 0);
    checkOutput("legal_state", state, 1);
    checkOutput("legal_count", count, 0);
    saw_bark = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(1'b0, 1'b1, (m_state == 1 && m_count == 5), 1'b0);
      saw_bark |= bark_irq;
    end
    checkOutput("kicked_no_bark", saw_bark, 0);

    // Ack from bark, then escalation to a bite that only rst clears.
    arm(5, 0, 0);
    runUntilState(2, "reach_bark");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("ack_state", state, 1);
    checkOutput("ack_bark", bark_irq, 0);
    checkOutput("ack_cause", cause, 0);
    runUntilState(2, "reach_bark2");
    runUntilState(3, "reach_expired");
    checkOutput("expired_bite", bite, 1);
    bite_dropped = 1'b0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
      if (!bite) bite_dropped = 1'b1;
    end
    checkOutput("bite_held", bite_dropped, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("rst_exp_state", state, 0);
    checkOutput("rst_exp_bite", bite, 0);
    checkOutput("rst_exp_bark", bark_irq, 0);

    // Coincident kick/tick and ack/expiry.
    arm(5, 0, 0);
    runToCount(4, 1'b1, "reach_expiring_tick");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("kick_wins_bark", bark_irq, 0);
    checkOutput("kick_wins_count", count, 0);
    runUntilState(2, "reach_bark3");
    runToCount(4, 1'b1, "reach_second_expiry");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("ack_wins_bite", bite, 0);
    checkOutput("ack_wins_state", state, 1);

    // Reset in bark, disarm in run, zero timeout.
    arm(5, 0, 0);
    runUntilState(2, "reach_bark4");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("rst_bark_state", state, 0);
    checkOutput("rst_bark_irq", bark_irq, 0);
    checkOutput("rst_bark_id", irq_id, 0);
    checkOutput("rst_bark_cause", cause, 0);
    arm(5, 0, 0);
    runToCount(2, 1'b0, "reach_count2");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("disarm_state", state, 0);
    checkOutput("disarm_count", count, 0);
    arm(0, 0, 0);
    first_bark = -1;
    while (cyc < 20) begin
      if (bark_irq && first_bark < 0) first_bark = cyc;
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    end
    checkOutput("zero_timeout_bark", first_bark, 11);

    // Randomized traffic against the model, config changing underneath.
    for (int seg = 0; seg < 15; seg++) begin
      arm($urandom_range(12, 0), ($urandom_range(2, 0) == 0) ? 0 : $urandom_range(6, 1),
          $urandom_range(8, 0));
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(99, 0) < 5) begin
          cfg_timeout = CNT_WIDTH'($urandom_range(12, 0));
          cfg_window  = CNT_WIDTH'($urandom_range(6, 0));
          cfg_warn    = CNT_WIDTH'($urandom_range(8, 0));
        end
        applyStimulus($urandom_range(999, 0) < 3, $urandom_range(99, 0) >= 2,
                      $urandom_range(99, 0) < 3, $urandom_range(99, 0) < 2);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
